pipe_stage_buf: RTL

Parametrised pipeline stage register for the CPU datapath, e.g. the EX/MEM boundary. The payload is the concatenated stage bundle: Instr, ALUout, RT, A3, PC4, PC8.
Adds a valid/ready handshake, an optional two-entry skid buffer that cuts the combinational ready path, and a synchronous flush that inserts a bubble. A saturating stall counter supports performance debug.
Replaces the fixed-width, always-load stage registers.

---
 rtl/pipe_stage_buf.sv | 132 +++++++++++++
 1 files changed

// File: rtl/pipe_stage_buf.sv
// Pipeline stage register with valid/ready handshake, optional two-entry
// skid buffer, synchronous flush and a saturating stall counter.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_EMPTY | no beat held, main holds BUBBLE_VAL, out_valid=0
// S_ONE   | one beat held in main, skid holds BUBBLE_VAL
// S_TWO   | main and skid both hold beats (SKID_EN=1 only), in_ready=0
module pipe_stage_buf #(
    parameter int unsigned       DATA_W     = 165,
    parameter bit                SKID_EN    = 1'b1,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = '0,
    parameter int unsigned       CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    input  logic              stat_clr
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_e            state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              main_v;
    logic              in_fire;
    logic              out_fire;

    assign main_v    = (state_q != S_EMPTY);
    assign out_valid = main_v;
    assign out_data  = main_q;
    // State encoding doubles as the held-beat count.
    assign occupancy = 2'(state_q);
    assign stall_cnt = cnt_q;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = main_v & out_ready;

    // Ready: registered-state-only with the skid, otherwise pass-through of out_ready.
    always_comb begin
        if (SKID_EN) begin
            in_ready = (state_q != S_TWO) && !flush;
        end else begin
            in_ready = (!main_v || out_ready) && !flush;
        end
    end

    // Next state and data movement; flush overrides every transition.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = S_EMPTY;
            main_d  = BUBBLE_VAL;
            skid_d  = BUBBLE_VAL;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (in_fire) begin
                        state_d = S_ONE;
                        main_d  = in_data;
                    end
                end
                S_ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data;
                    end else if (in_fire && SKID_EN) begin
                        state_d = S_TWO;
                        skid_d  = in_data;
                    end else if (out_fire) begin
                        state_d = S_EMPTY;
                        main_d  = BUBBLE_VAL;
                    end
                end
                S_TWO: begin
                    if (out_fire) begin
                        state_d = S_ONE;
                        main_d  = skid_q;
                        skid_d  = BUBBLE_VAL;
                    end
                end
                default: begin
                    state_d = S_EMPTY;
                    main_d  = BUBBLE_VAL;
                    skid_d  = BUBBLE_VAL;
                end
            endcase
        end
    end

    // Stall counter: clear wins, otherwise saturating count of stalled cycles.
    always_comb begin
        cnt_d = cnt_q;
        if (stat_clr) begin
            cnt_d = '0;
        end else if (main_v && !out_ready && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // State, payload and counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_EMPTY;
            main_q  <= BUBBLE_VAL;
            skid_q  <= BUBBLE_VAL;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
